// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding control block: PC select codes,
// forward-select codes, stall FSM states and the register-match helper.
package hazard_forward_unit_pkg;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BEQ = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] FWDJR_RF  = 2'b00;
    localparam logic [1:0] FWDJR_EX  = 2'b01;
    localparam logic [1:0] FWDJR_MEM = 2'b10;
    localparam logic [1:0] FWDJR_WB  = 2'b11;

    localparam logic [1:0] BUB_NONE = 2'd0;
    localparam logic [1:0] BUB_ONE  = 2'd1;
    localparam logic [1:0] BUB_TWO  = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_t;

    // $0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src,
                                     input logic en);
        return en && (dst == src) && (dst != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority forward-select: for each source register, pick the code of the
// youngest enabled producer level (0 youngest); 00 when nobody matches.
module hazard_fwd_sel
    import hazard_forward_unit_pkg::*;
#(
    parameter int         NSRC  = 2,
    parameter logic [1:0] CODE0 = FWD_MEM,
    parameter logic [1:0] CODE1 = FWD_WB,
    parameter logic [1:0] CODE2 = FWD_RF
) (
    input  logic [NSRC*5-1:0] src_i,
    input  logic [4:0]        dst0_i,
    input  logic              en0_i,
    input  logic [4:0]        dst1_i,
    input  logic              en1_i,
    input  logic [4:0]        dst2_i,
    input  logic              en2_i,
    output logic [NSRC*2-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (reg_hit(dst0_i, src_i[i*5 +: 5], en0_i)) begin
                sel_o[i*2 +: 2] = CODE0;
            end else if (reg_hit(dst1_i, src_i[i*5 +: 5], en1_i)) begin
                sel_o[i*2 +: 2] = CODE1;
            end else if (reg_hit(dst2_i, src_i[i*5 +: 5], en2_i)) begin
                sel_o[i*2 +: 2] = CODE2;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard/forwarding control for the 5-stage MIPS core: forward
// selects, load-use/jr stall FSM, branch/jump flushes, irq entry, counters.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic [2:0]       PCSrc,
    input  logic [4:0]       ID_EX_Rs,
    input  logic [4:0]       ID_EX_Rt,
    input  logic [4:0]       ID_EX_WriteReg,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_WriteReg,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       MEM_WB_WriteReg,
    input  logic             MEM_WB_RegWrite,
    input  logic             branch_taken,
    input  logic             irq,
    input  logic             in_kernel,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [1:0]       ForwardJR,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             irq_take,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_t        state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic             irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             is_jr;
    logic             load_use;
    logic             jr_ex_load;
    logic             jr_mem_load;
    logic [1:0]       bubbles;
    logic             stall;
    logic             br_flush;
    logic             jump_flush;
    logic             flush_evt;
    logic             take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + CNT_ONE;
        end
        return v;
    endfunction

    hazard_fwd_sel #(
        .NSRC  (2),
        .CODE0 (FWD_MEM),
        .CODE1 (FWD_WB),
        .CODE2 (FWD_RF)
    ) u_fwd_ab (
        .src_i  ({ID_EX_Rt, ID_EX_Rs}),
        .dst0_i (EX_MEM_WriteReg),
        .en0_i  (EX_MEM_RegWrite),
        .dst1_i (MEM_WB_WriteReg),
        .en1_i  (MEM_WB_RegWrite),
        .dst2_i (5'd0),
        .en2_i  (1'b0),
        .sel_o  ({ForwardB, ForwardA})
    );

    // Loads are excluded from the jr levels: their data is not ready, the stall covers them.
    hazard_fwd_sel #(
        .NSRC  (1),
        .CODE0 (FWDJR_EX),
        .CODE1 (FWDJR_MEM),
        .CODE2 (FWDJR_WB)
    ) u_fwd_jr (
        .src_i  (IF_ID_Rs),
        .dst0_i (ID_EX_WriteReg),
        .en0_i  (ID_EX_RegWrite && !ID_EX_MemRead),
        .dst1_i (EX_MEM_WriteReg),
        .en1_i  (EX_MEM_RegWrite && !EX_MEM_MemRead),
        .dst2_i (MEM_WB_WriteReg),
        .en2_i  (MEM_WB_RegWrite),
        .sel_o  (ForwardJR)
    );

    assign is_jr    = (PCSrc == PCSRC_JR);
    assign load_use = ID_EX_MemRead &&
                      (reg_hit(ID_EX_WriteReg, IF_ID_Rs, 1'b1) ||
                       reg_hit(ID_EX_WriteReg, IF_ID_Rt, IF_ID_UsesRt));
    assign jr_ex_load = is_jr && reg_hit(ID_EX_WriteReg, IF_ID_Rs, ID_EX_MemRead);
    // An EX/MEM load only matters to jr if no younger ID/EX writer shadows it.
    assign jr_mem_load = is_jr &&
                         !reg_hit(ID_EX_WriteReg, IF_ID_Rs, ID_EX_RegWrite) &&
                         reg_hit(EX_MEM_WriteReg, IF_ID_Rs, EX_MEM_MemRead);

    assign bubbles = jr_ex_load                ? BUB_TWO :
                     (load_use || jr_mem_load) ? BUB_ONE : BUB_NONE;

    assign stall      = !reset && !branch_taken &&
                        ((state_q == ST_HOLD) || (bubbles != BUB_NONE));
    assign br_flush   = !reset && branch_taken;
    assign jump_flush = !reset && ((PCSrc == PCSRC_J) || (is_jr && !stall));
    assign flush_evt  = br_flush || jump_flush;
    assign take       = !reset && irq_pend_q && (state_q == ST_RUN) && !stall &&
                        !branch_taken && (PCSrc == PCSRC_SEQ);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (branch_taken) begin
            state_d = ST_RUN;
            rem_d   = 2'd0;
        end else if (state_q == ST_HOLD) begin
            if (rem_q <= 2'd1) begin
                state_d = ST_RUN;
                rem_d   = 2'd0;
            end else begin
                rem_d = rem_q - 2'd1;
            end
        end else if (bubbles == BUB_TWO) begin
            state_d = ST_HOLD;
            rem_d   = bubbles - 2'd1;
        end
    end

    always_comb begin
        irq_pend_d  = take ? 1'b0 : (irq_pend_q || (irq && !in_kernel));
        stall_cnt_d = sat_inc(stall_cnt_q, stall);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_evt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            rem_q       <= 2'd0;
            irq_pend_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            irq_pend_q  <= irq_pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_Write     = !stall;
    assign IF_ID_Write  = !stall;
    assign IF_ID_Flush  = br_flush || jump_flush;
    assign ID_EX_Flush  = br_flush || stall;
    assign irq_take     = take;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding priority, load-use and jr
// stalls, branch override, interrupt gating, reset and counter saturation.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt;
    logic        IF_ID_UsesRt;
    logic [2:0]  PCSrc;
    logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_WriteReg;
    logic        ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0]  EX_MEM_WriteReg;
    logic        EX_MEM_RegWrite, EX_MEM_MemRead;
    logic [4:0]  MEM_WB_WriteReg;
    logic        MEM_WB_RegWrite;
    logic        branch_taken, irq, in_kernel;
    logic [1:0]  ForwardA, ForwardB, ForwardJR;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, irq_take;
    logic [15:0] stall_cycles, flush_events;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_Rs        (IF_ID_Rs),
        .IF_ID_Rt        (IF_ID_Rt),
        .IF_ID_UsesRt    (IF_ID_UsesRt),
        .PCSrc           (PCSrc),
        .ID_EX_Rs        (ID_EX_Rs),
        .ID_EX_Rt        (ID_EX_Rt),
        .ID_EX_WriteReg  (ID_EX_WriteReg),
        .ID_EX_RegWrite  (ID_EX_RegWrite),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .EX_MEM_WriteReg (EX_MEM_WriteReg),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .EX_MEM_MemRead  (EX_MEM_MemRead),
        .MEM_WB_WriteReg (MEM_WB_WriteReg),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .branch_taken    (branch_taken),
        .irq             (irq),
        .in_kernel       (in_kernel),
        .ForwardA        (ForwardA),
        .ForwardB        (ForwardB),
        .ForwardJR       (ForwardJR),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .irq_take        (irq_take),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_in();
        IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_UsesRt = 1'b0; PCSrc = 3'b000;
        ID_EX_Rs = 5'd0; ID_EX_Rt = 5'd0; ID_EX_WriteReg = 5'd0;
        ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
        EX_MEM_WriteReg = 5'd0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0;
        MEM_WB_WriteReg = 5'd0; MEM_WB_RegWrite = 1'b0;
        branch_taken = 1'b0; irq = 1'b0; in_kernel = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic chk_stall(input string tag, input logic exp_stall);
        chk({tag, ".pcw"},  PC_Write,    !exp_stall);
        chk({tag, ".ifw"},  IF_ID_Write, !exp_stall);
        chk({tag, ".idex"}, ID_EX_Flush, exp_stall);
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        tick();

        // Reset state
        do_reset();
        chk_stall("rst", 1'b0);
        chk("rst.ifflush", IF_ID_Flush, 1'b0);
        chk("rst.irq", irq_take, 1'b0);
        chk("rst.stallcnt", stall_cycles, 16'd0);
        chk("rst.flushcnt", flush_events, 16'd0);
        chk("rst.fwda", ForwardA, 2'b00);

        // Test 1: forwarding priority and $0
        EX_MEM_WriteReg = 5'd3; EX_MEM_RegWrite = 1'b1;
        MEM_WB_WriteReg = 5'd3; MEM_WB_RegWrite = 1'b1;
        ID_EX_Rs = 5'd3; ID_EX_Rt = 5'd4;
        #1;
        chk("t1.fwda_mem", ForwardA, 2'b10);
        chk("t1.fwdb_none", ForwardB, 2'b00);
        EX_MEM_RegWrite = 1'b0; ID_EX_Rt = 5'd3;
        #1;
        chk("t1.fwda_wb", ForwardA, 2'b01);
        chk("t1.fwdb_wb", ForwardB, 2'b01);
        EX_MEM_RegWrite = 1'b1; EX_MEM_WriteReg = 5'd0; MEM_WB_WriteReg = 5'd0;
        ID_EX_Rs = 5'd0; ID_EX_Rt = 5'd0;
        #1;
        chk("t1.fwda_r0", ForwardA, 2'b00);
        chk("t1.fwdb_r0", ForwardB, 2'b00);

        // jr forward select levels
        clear_in();
        PCSrc = 3'b011; IF_ID_Rs = 5'd7;
        ID_EX_WriteReg = 5'd7; ID_EX_RegWrite = 1'b1;
        EX_MEM_WriteReg = 5'd7; EX_MEM_RegWrite = 1'b1;
        MEM_WB_WriteReg = 5'd7; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("jr.ex", ForwardJR, 2'b01);
        chk("jr.ex_pcw", PC_Write, 1'b1);
        chk("jr.ex_flush", IF_ID_Flush, 1'b1);
        ID_EX_RegWrite = 1'b0;
        #1;
        chk("jr.mem", ForwardJR, 2'b10);
        EX_MEM_RegWrite = 1'b0;
        #1;
        chk("jr.wb", ForwardJR, 2'b11);
        MEM_WB_RegWrite = 1'b0;
        #1;
        chk("jr.none", ForwardJR, 2'b00);
        PCSrc = 3'b010;
        #1;
        chk("j.flush", IF_ID_Flush, 1'b1);
        chk("j.pcw", PC_Write, 1'b1);

        // Test 2: load-use on rt, single stall
        do_reset();
        ID_EX_WriteReg = 5'd5; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
        IF_ID_Rs = 5'd2; IF_ID_Rt = 5'd5; IF_ID_UsesRt = 1'b0;
        #1;
        chk("t2.nouse_pcw", PC_Write, 1'b1);
        IF_ID_UsesRt = 1'b1;
        #1;
        chk_stall("t2.stall", 1'b1);
        chk("t2.cnt0", stall_cycles, 16'd0);
        tick();
        ID_EX_WriteReg = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
        EX_MEM_WriteReg = 5'd5; EX_MEM_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        #1;
        chk_stall("t2.release", 1'b0);
        chk("t2.cnt1", stall_cycles, 16'd1);
        tick();
        ID_EX_Rs = 5'd2; ID_EX_Rt = 5'd5;
        EX_MEM_WriteReg = 5'd0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0;
        MEM_WB_WriteReg = 5'd5; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("t2.fwdb", ForwardB, 2'b01);
        chk("t2.fwda", ForwardA, 2'b00);
        chk("t2.cnt_hold", stall_cycles, 16'd1);

        // Test 3: jr after load, two stalls then release with WB forward
        do_reset();
        ID_EX_WriteReg = 5'd31; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
        PCSrc = 3'b011; IF_ID_Rs = 5'd31;
        #1;
        chk_stall("t3.s1", 1'b1);
        chk("t3.s1_ifflush", IF_ID_Flush, 1'b0);
        tick();
        ID_EX_WriteReg = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
        EX_MEM_WriteReg = 5'd31; EX_MEM_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        #1;
        chk_stall("t3.s2", 1'b1);
        chk("t3.s2_ifflush", IF_ID_Flush, 1'b0);
        chk("t3.s2_cnt", stall_cycles, 16'd1);
        tick();
        EX_MEM_WriteReg = 5'd0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0;
        MEM_WB_WriteReg = 5'd31; MEM_WB_RegWrite = 1'b1;
        #1;
        chk_stall("t3.rel", 1'b0);
        chk("t3.rel_fwdjr", ForwardJR, 2'b11);
        chk("t3.rel_ifflush", IF_ID_Flush, 1'b1);
        chk("t3.rel_cnt", stall_cycles, 16'd2);
        chk("t3.rel_fcnt", flush_events, 16'd0);
        tick();
        clear_in();
        #1;
        chk("t3.after_cnt", stall_cycles, 16'd2);
        chk("t3.after_fcnt", flush_events, 16'd1);

        // Test 4: branch overrides a load-use stall
        do_reset();
        ID_EX_WriteReg = 5'd5; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
        IF_ID_Rs = 5'd5; branch_taken = 1'b1;
        #1;
        chk("t4.ifflush", IF_ID_Flush, 1'b1);
        chk("t4.idexflush", ID_EX_Flush, 1'b1);
        chk("t4.pcw", PC_Write, 1'b1);
        chk("t4.ifw", IF_ID_Write, 1'b1);
        tick();
        clear_in();
        #1;
        chk_stall("t4.next", 1'b0);
        chk("t4.cnt", stall_cycles, 16'd0);
        chk("t4.fcnt", flush_events, 16'd1);

        // Test 5: irq held off by jr stall and non-sequential PC
        do_reset();
        ID_EX_WriteReg = 5'd31; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
        PCSrc = 3'b011; IF_ID_Rs = 5'd31; irq = 1'b1;
        #1;
        chk("t5.s1_take", irq_take, 1'b0);
        tick();
        ID_EX_WriteReg = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
        EX_MEM_WriteReg = 5'd31; EX_MEM_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        #1;
        chk("t5.hold_take", irq_take, 1'b0);
        tick();
        EX_MEM_WriteReg = 5'd0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0;
        MEM_WB_WriteReg = 5'd31; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("t5.rel_take", irq_take, 1'b0);
        chk("t5.rel_pcw", PC_Write, 1'b1);
        tick();
        clear_in();
        #1;
        chk("t5.take", irq_take, 1'b1);
        tick();
        chk("t5.after1", irq_take, 1'b0);
        tick();
        chk("t5.after2", irq_take, 1'b0);
        irq = 1'b1; in_kernel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5.kern%0d", i), irq_take, 1'b0);
        end
        irq = 1'b0; in_kernel = 1'b0;
        tick();
        chk("t5.kern_end", irq_take, 1'b0);

        // Test 6: reset during HOLD, then stall counter saturation
        do_reset();
        ID_EX_WriteReg = 5'd31; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
        PCSrc = 3'b011; IF_ID_Rs = 5'd31;
        tick();
        ID_EX_WriteReg = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
        #1;
        chk("t6.hold_pcw", PC_Write, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_in();
        #1;
        chk("t6.rst_pcw", PC_Write, 1'b1);
        chk("t6.rst_cnt", stall_cycles, 16'd0);
        chk("t6.rst_fcnt", flush_events, 16'd0);
        ID_EX_WriteReg = 5'd5; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
        IF_ID_Rs = 5'd5;
        repeat (65534) tick();
        chk("t6.cnt_fffe", stall_cycles, 16'hFFFE);
        repeat (7) tick();
        chk("t6.cnt_sat", stall_cycles, 16'hFFFF);
        chk("t6.sat_pcw", PC_Write, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Pipeline control block of the 5-stage MIPS CPU. Produces the ForwardA, ForwardB and ForwardJR selects consumed by the datapath mux block.
- Detects load-use and jr hazards and sequences the multi-cycle stall with a small FSM.
- Generates IF/ID and ID/EX flush on taken branches and jumps, arbitrates interrupt entry, and keeps saturating stall and flush counters.

Parameters:
CNT_W, 16, width of the stall_cycles and flush_events counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
IF_ID_Rs  in  5  rs field of the instruction in ID
IF_ID_Rt  in  5  rt field of the instruction in ID
IF_ID_UsesRt  in  1  ID instruction reads rt (R-type, beq, sw)
PCSrc  in  3  ID-stage PC select: 000 seq, 001 beq, 010 j/jal, 011 jr
ID_EX_Rs  in  5  rs of the instruction in EX
ID_EX_Rt  in  5  rt of the instruction in EX
ID_EX_WriteReg  in  5  destination register of the instruction in EX
ID_EX_RegWrite  in  1  EX instruction writes the register file
ID_EX_MemRead  in  1  EX instruction is a load
EX_MEM_WriteReg  in  5  destination register in MEM
EX_MEM_RegWrite  in  1  MEM instruction writes the register file
EX_MEM_MemRead  in  1  MEM instruction is a load
MEM_WB_WriteReg  in  5  destination register in WB
MEM_WB_RegWrite  in  1  WB instruction writes the register file
branch_taken  in  1  beq resolved taken in EX
irq  in  1  external interrupt request, level
in_kernel  in  1  PC[31] of the instruction in ID; masks irq
ForwardA  out  2  ALU A select: 00 register file, 01 DataBusC, 10 EX_MEM_ALUOUT
ForwardB  out  2  ALU B select, same encoding as ForwardA
ForwardJR  out  2  jr target select: 00 DataBusA, 01 ALUOUT, 10 EX/MEM result, 11 DataBusC
PC_Write  out  1  PC register enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  IF/ID register becomes a nop
ID_EX_Flush  out  1  ID/EX register becomes a bubble
irq_take  out  1  one-cycle pulse; the datapath takes the interrupt vector
stall_cycles  out  CNT_W  count of stalled cycles, saturating
flush_events  out  CNT_W  count of flush events, saturating

Behaviour:
- Register $0 is never a forwarding or hazard match.
- ForwardA/ForwardB are combinational. EX/MEM match with RegWrite gives 10. Otherwise a MEM/WB match gives 01. Otherwise 00. EX/MEM has priority.
- ForwardJR is combinational and significant only when PCSrc is 011. Each case lists the producer of IF_ID_Rs:
  - ID/EX non-load: 01.
  - EX/MEM non-load: 10.
  - MEM/WB: 11.
  - No producer: 00.
- Bubble requirement N, evaluated only in RUN:
  - ID/EX load whose WriteReg equals IF_ID_Rs, or equals IF_ID_Rt with UsesRt: N=1.
  - jr whose rs matches an ID/EX load: N=2.
  - jr whose rs matches an EX/MEM load: N=1.
  - jr whose rs matches a non-load in ID/EX: N=0, handled by forwarding.
- FSM states: RUN and HOLD, plus a 2-bit remaining-bubble count rem.
  - RUN with N>=1: stall this cycle. If N==2, go to HOLD with rem=1.
  - HOLD: stall. Decrement rem; return to RUN when rem reaches 0.
- Stall cycle: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
- branch_taken has the highest priority:
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1.
  - FSM forced to RUN with rem=0, because the stalled instruction is squashed.
  - flush_events increments by 1.
- Jump: PCSrc 010, or 011 with no stall this cycle, gives IF_ID_Flush=1 and flush_events +1. A jr that stalls flushes only on its release cycle.
- Interrupt:
  - irq_pending is set while irq=1 and in_kernel=0.
  - The interrupt is taken (irq_take=1, one cycle) only when all of these hold: pending, state RUN, no stall, no branch_taken, and PCSrc is 000.
  - irq_pending clears on the cycle after the take. A still-high irq may set it again.
- stall_cycles increments on every cycle with a stall and saturates at all-ones. flush_events saturates the same way.
- Reset, including mid-HOLD:
  - FSM state RUN, rem=0, irq_pending=0, both counters 0.
  - PC_Write=1, IF_ID_Write=1, flushes 0, irq_take=0.
  - Forward selects reflect the inputs (00 when the write enables are 0).

Decomposition:
- Shared package: PCSrc encodings (PCSRC_SEQ/BEQ/J/JR), the forward-select encodings (FWD_RF, FWD_WB, FWD_MEM, FWDJR_*), and the FSM state codes.
- One sub-module, hazard_fwd_sel: purely combinational forward-select logic, instanced once for A/B and once for JR.

Test Plan:
1. add $3 in EX/MEM, sub reading $3 in EX, same reg also in MEM/WB -> ForwardA=10 (EX/MEM wins); with $0 as destination -> 00.
2. lw $5 in ID/EX, add using $5 as rt in ID -> exactly 1 stall cycle: PC_Write=0, ID_EX_Flush=1; stall_cycles 0->1; then ForwardB=01.
3. lw $31 in ID/EX, jr $31 in ID -> 2 stall cycles (HOLD entered); release cycle ForwardJR=11 with IF_ID_Flush=1; stall_cycles=2, flush_events=1.
4. Load-use stall in progress when branch_taken=1 -> same cycle both flushes=1, PC_Write=1, FSM back to RUN next cycle, no further stall.
5. irq=1 while jr stalls -> irq_take stays 0 until the stall ends and PCSrc=000, then a single 1-cycle pulse. With in_kernel=1 -> never taken.
6. Reset asserted mid-HOLD -> next cycle PC_Write=1, counters 0; after 2^16+5 stalled cycles stall_cycles=16'hFFFF.
